// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
package inst_rom_loader_pkg;

  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD);

  localparam logic [INST_WIDTH-1:0] INST_ZERO = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch and byte-serial programming signals between the pc/loader side and the memory.
interface inst_rom_loader_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  import inst_rom_loader_pkg::*;

  logic                  ce;
  logic [ADDR_WIDTH-1:0] addr;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  ready;

  logic                  load_start;
  logic                  byte_valid;
  logic [BYTE_WIDTH-1:0] byte_data;
  logic                  byte_last;
  logic                  load_ready;
  logic                  load_done;

  modport master (
    output ce, addr, load_start, byte_valid, byte_data, byte_last,
    input  inst, inst_valid, ready, load_ready, load_done
  );

  modport slave (
    input  ce, addr, load_start, byte_valid, byte_data, byte_last,
    output inst, inst_valid, ready, load_ready, load_done
  );

endinterface

// File: rtl/inst_rom_loader_word_packer.sv
// Assembles MSB-first program bytes into 32-bit words; a short final word is left-justified.
module inst_rom_loader_word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  input  logic                  byte_last,
  output logic [INST_WIDTH-1:0] word_c,
  output logic                  word_strobe_c
);

  localparam logic [BYTE_CNT_WIDTH-1:0] CNT_FULL = BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1);

  logic [INST_WIDTH-1:0]     shift_q;
  logic [BYTE_CNT_WIDTH-1:0] cnt_q;
  logic [INST_WIDTH-1:0]     shifted_c;

  // Word including the incoming byte, zero-filled in the low bytes when it ends early.
  always_comb begin
    shifted_c     = {shift_q[INST_WIDTH-BYTE_WIDTH-1:0], byte_data};
    word_strobe_c = accept && (byte_last || (cnt_q == CNT_FULL));
    word_c        = shifted_c << (BYTE_WIDTH * 32'(CNT_FULL - cnt_q));
  end

  // Shift register and byte counter; restart empty after each emitted word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (word_strobe_c) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else begin
        shift_q <= shifted_c;
        cnt_q   <= cnt_q + BYTE_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory filled from a byte stream at run time, then served to the pc with 1-cycle latency.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 64
) (
  input  logic            clk,
  input  logic            rst,
  inst_rom_loader_if.slave bus
);

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH:0]   word_count_q;
  logic [INST_WIDTH-1:0] mem [DEPTH];

  logic [INST_WIDTH-1:0] inst_q;
  logic                  inst_valid_q;
  logic                  ready_q;
  logic                  load_ready_q;
  logic                  load_done_q;

  logic                  start_c;
  logic                  accept_c;
  logic                  last_slot_c;
  logic                  load_end_c;
  logic                  fetch_c;
  logic                  hit_c;
  logic [INST_WIDTH-1:0] word_c;
  logic                  word_strobe_c;

  assign start_c     = bus.load_start && (state_q != LOAD);
  assign accept_c    = (state_q == LOAD) && bus.byte_valid;
  assign last_slot_c = (wptr_q == ADDR_WIDTH'(DEPTH - 1));
  assign load_end_c  = word_strobe_c && (bus.byte_last || last_slot_c);
  assign fetch_c     = (state_q == RUN) && bus.ce && !bus.load_start;
  assign hit_c       = ({1'b0, bus.addr} < word_count_q);

  inst_rom_loader_word_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_c),
    .accept        (accept_c),
    .byte_data     (bus.byte_data),
    .byte_last     (bus.byte_last),
    .word_c        (word_c),
    .word_strobe_c (word_strobe_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_n;
  end

  // Next state: any load_start outside LOAD restarts programming.
  always_comb begin
    state_n = state_q;
    case (state_q)
      EMPTY:   if (bus.load_start) state_n = LOAD;
      LOAD:    if (load_end_c)     state_n = RUN;
      RUN:     if (bus.load_start) state_n = LOAD;
      default: state_n = EMPTY;
    endcase
  end

  // Write pointer and loaded word count; the pointer holds on the final slot rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || start_c) begin
      wptr_q       <= '0;
      word_count_q <= '0;
    end else if (word_strobe_c) begin
      if (load_end_c) word_count_q <= {1'b0, wptr_q} + (ADDR_WIDTH + 1)'(1);
      else            wptr_q       <= wptr_q + ADDR_WIDTH'(1);
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (word_strobe_c) mem[wptr_q] <= word_c;
  end

  // Registered fetch result and status flags; words beyond the loaded image read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q       <= INST_ZERO;
      inst_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      inst_q       <= (fetch_c && hit_c) ? mem[bus.addr] : INST_ZERO;
      inst_valid_q <= fetch_c;
      ready_q      <= (state_n == RUN);
      load_ready_q <= (state_n == LOAD);
      load_done_q  <= load_end_c;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.ready      = ready_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed table, corner sequences and randomized loads.
module tb_inst_rom_loader;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  typedef struct {
    logic        ce;
    logic [5:0]  addr;
    logic [31:0] inst;
    logic        valid;
  } fetch_vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

  inst_rom_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks;
  int          n_fail;
  logic [31:0] model_mem [DEPTH];
  int          model_count;
  logic [7:0]  byte_q [$];
  fetch_vec_t  vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ce         = 1'b0;
    bus.addr       = '0;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.byte_last  = 1'b0;
  endtask

  // Reference image: bytes grouped MSB-first in fours, short tail left-justified, at most DEPTH words.
  task automatic model_load();
    int n_eff;
    n_eff = (byte_q.size() < 4 * DEPTH) ? byte_q.size() : 4 * DEPTH;
    model_count = (n_eff + 3) / 4;
    for (int w = 0; w < model_count; w++) begin
      logic [31:0] word;
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < n_eff) word = word | ({24'h0, byte_q[4 * w + b]} << (24 - 8 * b));
      end
      model_mem[w] = word;
    end
  endtask

  function automatic logic [31:0] ref_inst(input logic [5:0] a);
    return (int'(a) < model_count) ? model_mem[a] : 32'h0;
  endfunction

  task automatic start_load(input logic with_ce, input logic [5:0] a);
    bus.load_start = 1'b1;
    bus.ce         = with_ce;
    bus.addr       = a;
    tick();
    bus.load_start = 1'b0;
    bus.ce         = 1'b0;
    chk("start_load_ready", 32'(bus.load_ready), 32'd1);
    chk("start_ready", 32'(bus.ready), 32'd0);
    chk("start_inst", bus.inst, 32'h0);
    chk("start_inst_valid", 32'(bus.inst_valid), 32'd0);
  endtask

  // Streams byte_q with random idle gaps and checks the single load_done pulse lands on the final byte.
  task automatic feed(input bit use_last, input int gap_max);
    int done_count;
    int done_idx;
    int n;
    int exp_idx;
    done_count = 0;
    done_idx   = -1;
    n          = byte_q.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        tick();
        if (bus.load_done) begin
          done_count++;
          done_idx = i - 1;
        end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = byte_q[i];
      bus.byte_last  = use_last && (i == n - 1);
      tick();
      if (bus.load_done) begin
        done_count++;
        done_idx = i;
      end
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    repeat (3) begin
      tick();
      if (bus.load_done) done_count++;
    end
    exp_idx = ((n < 4 * DEPTH) ? n : 4 * DEPTH) - 1;
    chk("load_done_pulses", 32'(done_count), 32'd1);
    chk("load_done_at_byte", 32'(done_idx), 32'(exp_idx));
    chk("ready_after_load", 32'(bus.ready), 32'd1);
    chk("load_ready_after_load", 32'(bus.load_ready), 32'd0);
    model_load();
  endtask

  task automatic fetch_exp(input string name, input logic [5:0] a,
                           input logic [31:0] exp, input logic exp_valid);
    bus.ce   = 1'b1;
    bus.addr = a;
    tick();
    bus.ce   = 1'b0;
    chk(name, bus.inst, exp);
    chk({name, "_valid"}, 32'(bus.inst_valid), 32'(exp_valid));
  endtask

  initial begin
    int done_seen;
    int n;

    vecs[0] = '{ce: 1'b1, addr: 6'd0,  inst: 32'h34080001, valid: 1'b1};
    vecs[1] = '{ce: 1'b1, addr: 6'd1,  inst: 32'h34090002, valid: 1'b1};
    vecs[2] = '{ce: 1'b1, addr: 6'd2,  inst: 32'h00000000, valid: 1'b1};
    vecs[3] = '{ce: 1'b0, addr: 6'd1,  inst: 32'h00000000, valid: 1'b0};
    vecs[4] = '{ce: 1'b1, addr: 6'd63, inst: 32'h00000000, valid: 1'b1};
    vecs[5] = '{ce: 1'b1, addr: 6'd0,  inst: 32'h34080001, valid: 1'b1};

    n_checks    = 0;
    n_fail      = 0;
    model_count = 0;
    idle_inputs();

    // Reset state, and fetches while EMPTY.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    fetch_exp("empty_fetch", 6'd0, 32'h0, 1'b0);

    // Two-word image, then table-driven fetches (back to back).
    start_load(1'b0, 6'd0);
    byte_q = '{8'h34, 8'h08, 8'h00, 8'h01, 8'h34, 8'h09, 8'h00, 8'h02};
    feed(1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      bus.ce   = vecs[i].ce;
      bus.addr = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_inst", i), bus.inst, vecs[i].inst);
      chk($sformatf("vec%0d_valid", i), 32'(bus.inst_valid), 32'(vecs[i].valid));
    end
    bus.ce = 1'b0;

    // Partial final word with idle gaps.
    start_load(1'b0, 6'd0);
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    feed(1'b1, 3);
    fetch_exp("part_w0", 6'd0, 32'h11223344, 1'b1);
    fetch_exp("part_w1", 6'd1, 32'hAA000000, 1'b1);
    fetch_exp("part_w2", 6'd2, 32'h0, 1'b1);

    // Full memory without byte_last: ends after word 63, later bytes ignored.
    start_load(1'b0, 6'd0);
    byte_q.delete();
    for (int i = 0; i < 260; i++) byte_q.push_back(8'(i));
    feed(1'b0, 0);
    fetch_exp("full_w63", 6'd63, 32'hFCFDFEFF, 1'b1);
    fetch_exp("full_w0", 6'd0, 32'h00010203, 1'b1);
    fetch_exp("full_w32", 6'd32, 32'h80818283, 1'b1);

    // load_start together with a fetch in RUN, then a one-word reload hides stale words.
    start_load(1'b1, 6'd5);
    byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    feed(1'b1, 1);
    fetch_exp("reload_w0", 6'd0, 32'hDEADBEEF, 1'b1);
    fetch_exp("reload_w1", 6'd1, 32'h0, 1'b1);

    // Reset in the middle of a load.
    start_load(1'b0, 6'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    tick();
    bus.byte_data  = 8'h66;
    tick();
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_count = 0;
    chk("midrst_load_ready", 32'(bus.load_ready), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd0);
    done_seen = 0;
    repeat (3) begin
      if (bus.load_done) done_seen++;
      tick();
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    fetch_exp("midrst_fetch", 6'd0, 32'h0, 1'b0);

    // Randomized loads checked against the reference image with random fetch traffic.
    for (int it = 0; it < 6; it++) begin
      start_load(1'b0, 6'd0);
      n = int'($urandom_range(40, 1));
      byte_q.delete();
      for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
      feed(1'b1, 2);
      for (int k = 0; k < 40; k++) begin
        logic       ce_r;
        logic [5:0] a_r;
        ce_r     = 1'($urandom_range(1, 0));
        a_r      = (k % 2 == 0) ? 6'($urandom_range(model_count, 0)) : 6'($urandom);
        bus.ce   = ce_r;
        bus.addr = a_r;
        tick();
        chk($sformatf("rand%0d_inst_a%0d", it, a_r), bus.inst, ce_r ? ref_inst(a_r) : 32'h0);
        chk($sformatf("rand%0d_valid", it), 32'(bus.inst_valid), 32'(ce_r));
      end
      bus.ce = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Responder end of the fetch interface. The PC side presents ce and a 6-bit word address; this block answers with a registered 32-bit instruction one cycle later.
- Adds a byte-serial programming port. The instruction memory is filled at run time from a loader stream and does not need to be preloaded from a file.
- Sits in place of the plain ROM, beside the pc unit, inside the fetch top level.

Parameters:
- ADDR_WIDTH, 6, word address width; matches the pc output width.
- DEPTH, 64, number of 32-bit words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- ce  input  1  fetch enable from the pc unit.
- addr  input  ADDR_WIDTH  fetch word address from the pc unit.
- inst  output  32  fetched instruction, registered.
- inst_valid  output  1  inst holds a real fetch result.
- ready  output  1  memory loaded and fetch-serviceable (state RUN).
- load_start  input  1  one-cycle request to begin (re)programming.
- byte_valid  input  1  byte_data is presented this cycle.
- byte_data  input  8  program byte; each word's most significant byte comes first.
- byte_last  input  1  qualifies the final byte of the image.
- load_ready  output  1  byte is accepted this cycle when byte_valid=1 (state LOAD).
- load_done  output  1  one-cycle pulse when loading completes.

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=EMPTY; inst=0; inst_valid=0; ready=0; load_ready=0; load_done=0.
  - wptr=0, byte_cnt=0, word_count=0.
  - Memory array contents are not reset.
- States: EMPTY, LOAD, RUN. Encoding is held in the shared package.
- EMPTY:
  - load_start -> LOAD, with wptr=0, byte_cnt=0, shift register=0.
  - Fetches return inst=0, inst_valid=0.
- LOAD:
  - load_ready=1.
  - An accepted byte shifts into the assembly register: word = {word[23:0], byte_data}. byte_cnt increments modulo 4.
  - On the 4th byte: write the word to mem[wptr] and increment wptr.
  - On byte_last with byte_cnt<3: left-justify the partial word, zero-fill the low bytes, then write it.
    - Example: 2 bytes AA,BB -> 0xAABB0000.
  - Load ends on either of:
    - an accepted byte_last;
    - the 4th byte of word DEPTH-1 (wptr would wrap). Further bytes are not accepted and wptr does not wrap.
  - At load end: word_count = number of words written (1..DEPTH), load_done=1 for the next cycle only, state -> RUN.
  - load_start during LOAD is ignored.
  - byte_valid=0 inserts idle cycles with no effect.
  - Fetches during LOAD: inst=0, inst_valid=0.
- RUN:
  - ready=1.
  - Latency is 1 cycle. If ce=1 at edge N, then after edge N+1: inst = mem[addr] when addr < word_count, else 0; inst_valid=1.
  - If ce=0, inst<=0 and inst_valid<=0 at the next edge.
  - A new fetch may be issued every cycle (fully pipelined).
- load_start in RUN:
  - Enter LOAD next cycle; ready drops the same edge.
  - wptr, byte_cnt and word_count clear to 0.
  - A fetch issued in the same cycle as load_start returns 0, inst_valid=0.
- rst mid-LOAD: returns to EMPTY, discards the partial word, leaves memory contents; word_count=0, so all fetches read 0 until a new load completes.
- Widths:
  - word_count is ADDR_WIDTH+1 bits so that DEPTH is representable.
  - addr is compared unsigned against word_count.

Decomposition:
- Shared package:
  - state encodings: EMPTY, LOAD, RUN;
  - INST_WIDTH=32, BYTE_WIDTH=8, BYTES_PER_WORD=4;
  - the zero-instruction constant (32'h0).
- One natural sub-module: word_packer.
  - Byte-to-word shift register with a 2-bit counter.
  - Outputs word and word_strobe, and does the zero-fill on last.
  - The top block owns the FSM, memory array, wptr/word_count and the fetch pipeline.

Test Plan:
1. Reset -> inst=0, inst_valid=0, ready=0, load_ready=0. Then ce=1 with addr=0 -> inst stays 0 and inst_valid stays 0.
2. load_start, then bytes 34 08 00 01, 34 09 00 02 with byte_last on the final byte -> load_done pulses once, ready=1. Then ce=1: addr=0 -> 0x34080001 and addr=1 -> 0x34090002, each one cycle later with inst_valid=1. addr=2 -> 0.
3. Stream 5 bytes 11 22 33 44 AA, last on AA, with byte_valid gaps inserted -> mem[0]=0x11223344, mem[1]=0xAA000000, word_count=2.
4. Stream 256 bytes without byte_last -> load ends after 64 words, load_done=1, load_ready=0 afterwards. addr=63 returns the final word.
5. In RUN, assert load_start together with ce=1 -> inst=0, inst_valid=0, ready=0 next cycle. Reload 1 word 0xDEADBEEF -> addr=0 returns 0xDEADBEEF and addr=1 returns 0 (stale data hidden).
6. rst after 2 bytes of a load -> state EMPTY, load_ready=0, no load_done pulse, fetches return 0.
